// File: rtl/fsb_word_packer.sv
// Width converter between 32-bit host words and 80-bit FSB packets.
// Packs three host words into a TX packet FIFO; unpacks RX packets into three host words.

module fsb_word_packer_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    w_count;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign w_count = r_wptr - r_rptr;
  assign o_count = w_count;
  assign o_full  = (w_count == PW'(DEPTH));
  assign o_empty = (w_count == '0);
  assign o_head  = r_mem[r_rptr[PW-2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      // NOTE: storage is cleared here so the head output reads zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      if (i_push && !o_full) begin
        r_mem[r_wptr[PW-2:0]] <= i_push_data;
        r_wptr                <= r_wptr + PW'(1);
      end
      if (i_pop && !o_empty) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end
endmodule

module fsb_word_packer #(
  parameter int FSB_WIDTH  = 80,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_main_a0,
  input  logic                          rst_main_n,
  input  logic [31:0]                   wr_data_i,
  input  logic                          wr_v_i,
  output logic                          wr_ready_o,
  output logic [FSB_WIDTH-1:0]          fsb_data_o,
  output logic                          fsb_v_o,
  input  logic                          fsb_yumi_i,
  input  logic [FSB_WIDTH-1:0]          fsb_data_i,
  input  logic                          fsb_v_i,
  output logic                          fsb_ready_o,
  output logic [31:0]                   rd_data_o,
  output logic                          rd_v_o,
  input  logic                          rd_yumi_i,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o
);

  if (FSB_WIDTH != 80) begin : g_bad_fsb_width
    $error("fsb_word_packer: FSB_WIDTH must be 80");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("fsb_word_packer: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    WORD0 = 2'd0,
    WORD1 = 2'd1,
    WORD2 = 2'd2
  } word_sel_e;

  // ---------------- TX packer ----------------
  word_sel_e              r_tx_sel;
  logic [63:0]            r_asm;
  logic                   w_wr_fire;
  logic                   w_tx_push;
  logic [FSB_WIDTH-1:0]   w_tx_push_data;
  logic                   w_tx_full;
  logic                   w_tx_empty;

  // Back-pressure only the packet-completing word; no bypass from a same-cycle pop.
  assign wr_ready_o     = !(r_tx_sel == WORD2 && w_tx_full);
  assign w_wr_fire      = wr_v_i && wr_ready_o;
  assign w_tx_push      = w_wr_fire && (r_tx_sel == WORD2);
  assign w_tx_push_data = {wr_data_i[15:0], r_asm};

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_tx_sel <= WORD0;
      r_asm    <= '0;
    end else if (w_wr_fire) begin
      case (r_tx_sel)
        WORD0: begin
          r_asm[31:0] <= wr_data_i;
          r_tx_sel    <= WORD1;
        end
        WORD1: begin
          r_asm[63:32] <= wr_data_i;
          r_tx_sel     <= WORD2;
        end
        default: begin
          r_tx_sel <= WORD0;
        end
      endcase
    end
  end

  fsb_word_packer_fifo #(
    .WIDTH (FSB_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk_main_a0),
    .rst_n       (rst_main_n),
    .i_push      (w_tx_push),
    .i_push_data (w_tx_push_data),
    .i_pop       (fsb_yumi_i),
    .o_head      (fsb_data_o),
    .o_count     (tx_count_o),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty)
  );

  assign fsb_v_o = !w_tx_empty;

  // ---------------- RX unpacker ----------------
  word_sel_e              r_rd_sel;
  logic [FSB_WIDTH-1:0]   w_rx_head;
  logic                   w_rx_push;
  logic                   w_rx_pop;
  logic                   w_rd_fire;
  logic                   w_rx_full;
  logic                   w_rx_empty;

  assign fsb_ready_o = !w_rx_full;
  assign w_rx_push   = fsb_v_i && fsb_ready_o;
  assign rd_v_o      = !w_rx_empty;
  assign w_rd_fire   = rd_yumi_i && rd_v_o;
  assign w_rx_pop    = w_rd_fire && (r_rd_sel == WORD2);

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_rd_sel <= WORD0;
    end else if (w_rd_fire) begin
      case (r_rd_sel)
        WORD0:   r_rd_sel <= WORD1;
        WORD1:   r_rd_sel <= WORD2;
        default: r_rd_sel <= WORD0;
      endcase
    end
  end

  fsb_word_packer_fifo #(
    .WIDTH (FSB_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk         (clk_main_a0),
    .rst_n       (rst_main_n),
    .i_push      (w_rx_push),
    .i_push_data (fsb_data_i),
    .i_pop       (w_rx_pop),
    .o_head      (w_rx_head),
    .o_count     (rx_count_o),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty)
  );

  always_comb begin
    // NOTE: assigning a default first keeps this block free of inferred latches.
    rd_data_o = '0;
    case (r_rd_sel)
      WORD0:   rd_data_o = w_rx_head[31:0];
      WORD1:   rd_data_o = w_rx_head[63:32];
      WORD2:   rd_data_o = {16'h0, w_rx_head[79:64]};
      default: rd_data_o = '0;
    endcase
  end

endmodule
